// File: rtl/param_cpu_core.sv
// rtl/param_cpu_core.sv - parametrised multi-cycle load/store CPU core
//
// Multi-cycle core with a 16-bit instruction word, 8 x DATA_W register file,
// internal instruction memory (written through the program port while idle
// or halted) and internal data memory.
//
// Optional feature macro: CPU_MUL_EN (opcode C = MUL when defined, NOP otherwise).
//
// Ports:
//   CLK         clock, rising edge
//   RESET       asynchronous active-high reset
//   start       pulse; starts execution from IDLE or HALT (HALT restarts at pc 0)
//   prog_we     instruction memory write strobe (ignored while busy)
//   prog_addr   instruction memory write address
//   prog_data   instruction word to write
//   dbg_sel     register index for the debug read port
//   dbg_data    combinational read of regs[dbg_sel]
//   pc          current program counter
//   busy        high in FETCH/EXEC/MEM
//   halted      high in HALT
//   zero_flag   result==0 of the last ALU op
//   carry_flag  ADD carry-out / SUB borrow of the last ADD/SUB
//   retired     retired-instruction count, wraps at 2**16

module param_cpu_core #(
    parameter int DATA_W  = 8,
    parameter int IMEM_AW = 5,
    parameter int DMEM_AW = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    input  logic [2:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [IMEM_AW-1:0] pc,
    output logic               busy,
    output logic               halted,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic [15:0]        retired
);
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t state, state_nx;

    logic [15:0]        imem [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem [2**DMEM_AW];
    logic [DATA_W-1:0]  regs [8];
    logic [15:0]        ir;

    logic [3:0]         op;
    logic [2:0]         rd, rs1, rs2;
    logic [7:0]         imm8;
    logic [DATA_W-1:0]  a, b;

    logic [DATA_W-1:0]  alu_res;
    logic               alu_carry;
    logic               wr_en, upd_z, upd_c, br_taken;
    logic [IMEM_AW-1:0] pc_nx;
    logic               prog_ok;

    assign op   = ir[15:12];
    assign rd   = ir[11:9];
    assign rs1  = ir[8:6];
    assign rs2  = ir[5:3];
    assign imm8 = ir[7:0];
    assign a    = regs[rs1];
    assign b    = regs[rs2];

    assign dbg_data = regs[dbg_sel];
    assign busy     = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign halted   = (state == S_HALT);
    assign prog_ok  = (state == S_IDLE) || (state == S_HALT);

    // Execute-stage datapath; only consumed while state == S_EXEC.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        wr_en     = 1'b0;
        upd_z     = 1'b0;
        upd_c     = 1'b0;
        br_taken  = 1'b0;
        case (op)
            4'h1: begin alu_res = DATA_W'(imm8); wr_en = 1'b1; end
            4'h2: begin alu_res = a; wr_en = 1'b1; end
            4'h3: begin
                {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
                wr_en = 1'b1; upd_z = 1'b1; upd_c = 1'b1;
            end
            // Top bit of the widened difference is the unsigned borrow.
            4'h4: begin
                {alu_carry, alu_res} = {1'b0, a} - {1'b0, b};
                wr_en = 1'b1; upd_z = 1'b1; upd_c = 1'b1;
            end
            4'h5: begin alu_res = a & b; wr_en = 1'b1; upd_z = 1'b1; end
            4'h6: begin alu_res = a | b; wr_en = 1'b1; upd_z = 1'b1; end
            4'h7: begin alu_res = a >> b[SH_W-1:0]; wr_en = 1'b1; upd_z = 1'b1; end
            4'hA: br_taken = (a == '0);
            4'hB: br_taken = 1'b1;
`ifdef CPU_MUL_EN
            4'hC: begin alu_res = a * b; wr_en = 1'b1; upd_z = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        pc_nx = pc + IMEM_AW'(1);
        if (br_taken)
            pc_nx = IMEM_AW'(imm8);
        else if (op == 4'hF)
            pc_nx = pc;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
            S_FETCH:        state_nx = S_EXEC;
            S_EXEC: begin
                if (op == 4'h8)
                    state_nx = S_MEM;
                else if (op == 4'hF)
                    state_nx = S_HALT;
                else
                    state_nx = S_FETCH;
            end
            S_MEM:          state_nx = S_FETCH;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc         <= '0;
            ir         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            retired    <= '0;
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_HALT: if (start) pc <= '0;
                S_FETCH: ir <= imem[pc];
                S_EXEC: begin
                    if (wr_en) regs[rd] <= alu_res;
                    if (upd_z) zero_flag <= (alu_res == '0);
                    if (upd_c) carry_flag <= alu_carry;
                    pc <= pc_nx;
                    // LD retires at the end of its MEM cycle instead.
                    if (op != 4'h8) retired <= retired + 16'd1;
                end
                S_MEM: begin
                    regs[rd] <= dmem[a[DMEM_AW-1:0]];
                    retired  <= retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Memories are not cleared by RESET.
    always_ff @(posedge CLK) begin
        if (prog_we && prog_ok)
            imem[prog_addr] <= prog_data;
        if (state == S_EXEC && op == 4'h9)
            dmem[a[DMEM_AW-1:0]] <= b;
    end

endmodule

// File: tb/tb_param_cpu_core.sv
// tb/tb_param_cpu_core.sv - self-checking bench for param_cpu_core against an ISA-level model

module tb_param_cpu_core;
    localparam int DW  = 8;
    localparam int IAW = 5;
    localparam int DAW = 4;
    localparam int ID  = 32;
    localparam int DD  = 16;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           start = 1'b0;
    logic           prog_we = 1'b0;
    logic [IAW-1:0] prog_addr = '0;
    logic [15:0]    prog_data = '0;
    logic [2:0]     dbg_sel = '0;
    logic [DW-1:0]  dbg_data;
    logic [IAW-1:0] pc;
    logic           busy, halted, zero_flag, carry_flag;
    logic [15:0]    retired;

    param_cpu_core #(.DATA_W(DW), .IMEM_AW(IAW), .DMEM_AW(DAW)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .pc(pc), .busy(busy), .halted(halted),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .retired(retired)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural reference state
    longint      m_reg [8];
    longint      m_dmem [DD];
    logic [15:0] m_imem [ID];
    int          m_z, m_c, m_ret, m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins_r(input int op, input int rd, input int rs1, input int rs2);
        return 16'((op << 12) | (rd << 9) | (rs1 << 6) | (rs2 << 3));
    endfunction

    function automatic logic [15:0] ins_i(input int op, input int rd, input int imm);
        return 16'((op << 12) | (rd << 9) | (imm & 255));
    endfunction

    function automatic logic [15:0] ins_b(input int op, input int rs1, input int tgt);
        return 16'((op << 12) | (rs1 << 6) | (tgt & 31));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_z = 0; m_c = 0; m_ret = 0; m_pc = 0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < ID; i++) m_imem[i] = 16'hF000;
    endtask

    // Runs the program from address 0 to HALT; returns cycles from first FETCH to HALT.
    task automatic model_run(output int cyc);
        longint mask;
        longint a, b, r;
        logic [15:0] w;
        int op, rd, rs1, rs2, imm, nxt;
        bit halt;
        mask = (longint'(1) << DW) - 1;
        halt = 0;
        m_pc = 0;
        cyc = 0;
        for (int steps = 0; steps < 1000 && !halt; steps++) begin
            w = m_imem[m_pc];
            op = int'(w[15:12]); rd = int'(w[11:9]); rs1 = int'(w[8:6]);
            rs2 = int'(w[5:3]); imm = int'(w[7:0]);
            a = m_reg[rs1]; b = m_reg[rs2];
            nxt = (m_pc + 1) % ID;
            cyc += 2;
            case (op)
                1: m_reg[rd] = imm;
                2: m_reg[rd] = a;
                3: begin r = a + b; m_c = int'(r > mask); r = r & mask; m_z = int'(r == 0); m_reg[rd] = r; end
                4: begin m_c = int'(a < b); r = (a - b) & mask; m_z = int'(r == 0); m_reg[rd] = r; end
                5: begin r = a & b; m_z = int'(r == 0); m_reg[rd] = r; end
                6: begin r = a | b; m_z = int'(r == 0); m_reg[rd] = r; end
                7: begin r = a >> (b % (1 << $clog2(DW))); m_z = int'(r == 0); m_reg[rd] = r; end
                8: begin m_reg[rd] = m_dmem[a % DD]; cyc += 1; end
                9: m_dmem[a % DD] = b;
                10: if (a == 0) nxt = imm % ID;
                11: nxt = imm % ID;
`ifdef CPU_MUL_EN
                12: begin r = (a * b) & mask; m_z = int'(r == 0); m_reg[rd] = r; end
`endif
                15: begin halt = 1; nxt = m_pc; end
                default: ;
            endcase
            m_ret = (m_ret + 1) % 65536;
            m_pc = nxt;
        end
        if (!halt) cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic load_prog();
        for (int i = 0; i < ID; i++) begin
            @(negedge CLK);
            prog_we = 1'b1; prog_addr = IAW'(i); prog_data = m_imem[i];
        end
        @(negedge CLK);
        prog_we = 1'b0;
    endtask

    task automatic get_reg(input int i, output logic [DW-1:0] v);
        dbg_sel = 3'(i);
        #1;
        v = dbg_data;
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            get_reg(i, v);
            check($sformatf("%s_r%0d", tag, i), 32'(v), 32'(m_reg[i]));
        end
        check({tag, "_zero"}, 32'(zero_flag), 32'(m_z));
        check({tag, "_carry"}, 32'(carry_flag), 32'(m_c));
        check({tag, "_retired"}, 32'(retired), 32'(m_ret));
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    endtask

    // mode 0: plain run; mode 1: prog write + start while busy (both must be ignored);
    // mode 2: prog write in the same cycle as start (must land before the fetch).
    task automatic run(input string tag, input int mode, input int wa, input logic [15:0] wd,
                       output int got_cyc);
        int exp_cyc, n;
        @(negedge CLK);
        start = 1'b1;
        if (mode == 2) begin
            prog_we = 1'b1; prog_addr = IAW'(wa); prog_data = wd;
            m_imem[wa] = wd;
        end
        model_run(exp_cyc);
        @(posedge CLK);
        #1;
        start = 1'b0;
        prog_we = 1'b0;
        check({tag, "_start_pc"}, 32'(pc), 32'd0);
        check({tag, "_start_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!halted && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
            if (mode == 1 && n == 2) begin
                prog_we = 1'b1; prog_addr = IAW'(wa); prog_data = wd; start = 1'b1;
            end else if (mode == 1 && n == 3) begin
                prog_we = 1'b0; start = 1'b0;
            end
        end
        prog_we = 1'b0;
        start = 1'b0;
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        check_state(tag);
        got_cyc = n;
    endtask

    initial begin
        int cyc;
        logic [DW-1:0] v;

        for (int i = 0; i < DD; i++) m_dmem[i] = 0;
        clear_prog();
        do_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check_state("rst");

        // Basic add
        clear_prog();
        m_imem[0] = ins_i(1, 1, 5);
        m_imem[1] = ins_i(1, 2, 3);
        m_imem[2] = ins_r(3, 3, 1, 2);
        load_prog();
        run("add", 0, 0, 16'h0, cyc);
        check("add_cycles_8", 32'(cyc), 32'd8);
        get_reg(3, v);
        check("add_r3_8", 32'(v), 32'd8);
        check("add_retired_4", 32'(retired), 32'd4);

        // Carry/borrow/zero, plus ignored program write and start while busy
        clear_prog();
        m_imem[0] = ins_i(1, 1, 8'hF0);
        m_imem[1] = ins_i(1, 2, 8'h20);
        m_imem[2] = ins_r(3, 3, 1, 2);
        m_imem[3] = ins_r(4, 4, 2, 1);
        m_imem[4] = ins_r(4, 5, 1, 1);
        load_prog();
        run("carry", 1, 4, ins_i(1, 5, 8'hAA), cyc);
        get_reg(3, v); check("carry_r3", 32'(v), 32'h10);
        get_reg(4, v); check("carry_r4", 32'(v), 32'h30);
        get_reg(5, v); check("carry_r5", 32'(v), 32'h0);
        check("carry_zero", 32'(zero_flag), 32'd1);

        // Give every DMEM word a known value
        for (int h = 0; h < 2; h++) begin
            clear_prog();
            for (int k = 0; k < 8; k++) begin
                m_imem[3*k]   = ins_i(1, 2, int'($urandom_range(0, 255)));
                m_imem[3*k+1] = ins_i(1, 1, h * 8 + k);
                m_imem[3*k+2] = ins_r(9, 0, 1, 2);
            end
            load_prog();
            run("dinit", 0, 0, 16'h0, cyc);
        end

        // Store/load, word 0 rewritten in the start cycle
        clear_prog();
        m_imem[0] = ins_i(1, 1, 7);
        m_imem[1] = ins_i(1, 2, 8'h55);
        m_imem[2] = ins_r(9, 0, 1, 2);
        m_imem[3] = ins_r(8, 6, 1, 0);
        load_prog();
        run("stld", 2, 0, ins_i(1, 1, 2), cyc);
        get_reg(6, v); check("stld_r6", 32'(v), 32'h55);

        // Reset during the MEM cycle of a load
        clear_prog();
        m_imem[0] = ins_i(1, 1, 2);
        m_imem[1] = ins_r(8, 6, 1, 0);
        load_prog();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("midld_busy", 32'(busy), 32'd1);
        check("midld_pc", 32'(pc), 32'd2);
        RESET = 1'b1;
        #1;
        check("midld_rst_busy", 32'(busy), 32'd0);
        check("midld_rst_pc", 32'(pc), 32'd0);
        check("midld_rst_retired", 32'(retired), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        check("midld_idle", 32'(busy), 32'd0);
        check_state("midld");

        // Taken branch on r0
        clear_prog();
        m_imem[0] = ins_b(10, 0, 6);
        load_prog();
        run("bz", 0, 0, 16'h0, cyc);
        check("bz_pc_6", 32'(pc), 32'd6);

        // JMP to the last address, NOP there wraps pc to 0
        clear_prog();
        m_imem[0]  = ins_b(10, 7, 5);
        m_imem[5]  = ins_i(1, 7, 1);
        m_imem[6]  = ins_b(11, 0, 31);
        m_imem[31] = 16'h0000;
        load_prog();
        run("wrap", 0, 0, 16'h0, cyc);
        check("wrap_pc_1", 32'(pc), 32'd1);

        // Opcode C
        clear_prog();
        m_imem[0] = ins_i(1, 1, 8'h13);
        m_imem[1] = ins_i(1, 2, 8'h11);
        m_imem[2] = ins_i(1, 3, 8'h77);
        m_imem[3] = ins_r(12, 3, 1, 2);
        load_prog();
        run("mul", 0, 0, 16'h0, cyc);
        get_reg(3, v);
`ifdef CPU_MUL_EN
        check("mul_r3", 32'(v), 32'h43);
`else
        check("mul_r3", 32'(v), 32'h77);
`endif

        // Random forward-only programs
        for (int p = 0; p < 8; p++) begin
            int op;
            clear_prog();
            for (int i = 0; i < ID - 1; i++) begin
                op = int'($urandom_range(0, 14));
                if (op == 10 || op == 11)
                    m_imem[i] = ins_b(op, int'($urandom_range(0, 7)), int'($urandom_range(i + 1, ID - 1)));
                else
                    m_imem[i] = 16'((op << 12) | int'($urandom & 32'hFFF));
            end
            load_prog();
            run($sformatf("rnd%0d", p), 0, 0, 16'h0, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_cpu_core.md
Name: param_cpu_core

Overview:
Parametrised successor to the team's 8-bit accumulator CPU. Multi-cycle load/store core with a 16-bit fixed instruction word, an 8-entry register file of DATA_W bits, an internal instruction memory loaded through a program port, and an internal data memory. Sits as the compute engine of the tile, driven by an external loader/sequencer that writes the program, pulses start, and monitors halted.

Parameters:
DATA_W, 8, register/ALU/data-memory word width; legal values 8..32.
IMEM_AW, 5, instruction memory address width; depth 2**IMEM_AW words of 16 bits.
DMEM_AW, 4, data memory address width; depth 2**DMEM_AW words of DATA_W bits.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; begins execution from IDLE or HALT.
prog_we  in  1  instruction memory write strobe.
prog_addr  in  IMEM_AW  instruction memory write address.
prog_data  in  16  instruction word to write.
dbg_sel  in  3  register index for the debug read port.
dbg_data  out  DATA_W  combinational read of regfile[dbg_sel].
pc  out  IMEM_AW  current program counter.
busy  out  1  high in FETCH/EXEC/MEM.
halted  out  1  high in HALT.
zero_flag  out  1  result==0 of the last ALU op.
carry_flag  out  1  ADD carry-out / SUB borrow of the last ADD/SUB.
retired  out  16  retired-instruction count, wraps at 2**16.

Behaviour:
- Reset is fixed: one clock CLK; RESET asynchronous, active-high. On RESET: state=IDLE, pc=0, all 8 registers=0, flags=0, retired=0, busy=0, halted=0. IMEM/DMEM contents are not cleared.
- Instruction fields: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8. imm8 is zero-extended to DATA_W.
- Opcodes: 0 NOP; 1 LDI rd=imm8; 2 MOV rd=rs1; 3 ADD rd=rs1+rs2; 4 SUB rd=rs1-rs2; 5 AND; 6 OR; 7 SRL rd=rs1>>rs2[log2(DATA_W)-1:0]; 8 LD rd=DMEM[rs1[DMEM_AW-1:0]]; 9 ST DMEM[rs1[DMEM_AW-1:0]]=rs2; A BZ: if rs1==0 then pc=imm8[IMEM_AW-1:0]; B JMP pc=imm8[IMEM_AW-1:0]; C see Optional Feature; F HALT. Opcodes D and E execute as NOP.
- Arithmetic is modulo 2**DATA_W. zero_flag is updated by ops 3-7 (and C when enabled). carry_flag is updated by ADD/SUB only; for SUB, carry_flag=1 iff rs1<rs2 unsigned.
- FSM states: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE/HALT + start: go to FETCH. From HALT, pc is first reset to 0. Registers, flags and retired are kept.
  - FETCH: synchronous IMEM read at pc. Next state is EXEC.
  - EXEC: register writeback and ST occur at the end of this cycle.
    - LD goes to MEM.
    - HALT goes to HALT; pc holds at the HALT address.
    - Any other op goes to FETCH.
    - Next pc = branch target if taken, else pc+1, wrapping modulo 2**IMEM_AW.
  - MEM: synchronous DMEM read; rd is written at the end of MEM. Next state is FETCH.
- Latency: ALU/branch/ST/NOP instructions take 2 cycles; LD takes 3; retired increments on the final cycle of each instruction, including HALT.
- Program port: a write is accepted only when state is IDLE or HALT; writes while busy are dropped. prog_we and start in the same cycle: the write lands, and the subsequent FETCH sees the new word.
- start while busy is ignored.
- Reset mid-instruction aborts it. No register or DMEM write occurs from that instruction unless its write edge preceded RESET.

Optional Feature:
CPU_MUL_EN: when defined, opcode C = MUL, rd = low DATA_W bits of rs1*rs2. It takes the 2-cycle path and updates zero_flag; carry_flag is unchanged. When undefined, opcode C is a NOP and no multiplier is synthesised.

Test Plan:
- Reset, then load LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT; pulse start -> halted after 8 cycles; dbg_sel=3 gives 8; retired=4; carry_flag=0; zero_flag=0.
- DATA_W=8: LDI r1,0xF0; LDI r2,0x20; ADD r3 -> r3=0x10, carry_flag=1; then SUB r4,r2,r1 -> r4=0x30, carry_flag=1; SUB r5,r1,r1 -> r5=0, zero_flag=1.
- ST [r1=2],r2=0x55; LD r6,[r1] -> r6=0x55; the LD spans 3 cycles (busy throughout); pc advances by 1.
- BZ r0(=0),imm=6 lands pc=6; JMP to IMEM_AW max address followed by a NOP -> pc wraps to 0.
- prog_we pulsed while busy -> IMEM unchanged; start pulsed from HALT -> pc=0 and registers retained; RESET asserted mid-LD -> IDLE, registers 0, rd not written.
- CPU_MUL_EN defined: MUL of 0x13*0x11 -> 0x43. Undefined: the same op leaves rd unchanged; retired still increments.
